// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline (P) and long-latency (M) writeback,
// with a starvation guard for M and a pending-destination scoreboard for issue stalls.
module rf_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [4:0]        p_rd,
    input  logic [XLEN-1:0]   p_data,
    output logic              p_ready,
    input  logic              m_valid,
    input  logic [4:0]        m_rd,
    input  logic [XLEN-1:0]   m_data,
    output logic              m_ready,
    input  logic              issue_en,
    input  logic [4:0]        issue_rd,
    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [31:0]       busy_mask,
    output logic              issue_err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_m;
    logic             p_acc;
    logic             m_acc;
    logic             any_acc;
    logic [4:0]       win_rd;
    logic [XLEN-1:0]  win_data;
    logic [31:0]      busy_next;

    // Arbitration: P has priority unless M has been refused STARVE_LIMIT times in a row.
    always_comb begin
        p_ready = 1'b0;
        m_ready = 1'b0;
        force_m = (starve_cnt == LIMIT) && m_valid;
        if (force_m) begin
            m_ready = 1'b1;
        end else if (p_valid) begin
            p_ready = 1'b1;
        end else begin
            m_ready = m_valid;
            p_ready = !m_valid;
        end
        p_acc    = p_valid && p_ready;
        m_acc    = m_valid && m_ready;
        any_acc  = p_acc || m_acc;
        win_rd   = m_acc ? m_rd : p_rd;
        win_data = m_acc ? m_data : p_data;
    end

    // Scoreboard next state; a same-cycle issue overrides the M clear of that register.
    always_comb begin
        busy_next = busy_mask;
        if (m_acc) begin
            busy_next[m_rd] = 1'b0;
        end
        if (issue_en && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wdata   <= '0;
            busy_mask  <= '0;
            issue_err  <= 1'b0;
        end else begin
            if (m_acc) begin
                starve_cnt <= '0;
            end else if (m_valid && !m_ready && (starve_cnt < LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            // x0 writes complete the handshake but never reach the register file.
            rf_we <= any_acc && (win_rd != 5'd0);
            if (any_acc) begin
                rf_rd    <= win_rd;
                rf_wdata <= win_data;
            end

            busy_mask <= busy_next;
            if (issue_en && busy_mask[issue_rd]) begin
                issue_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (XLEN=32, STARVE_LIMIT=3).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid, m_valid, issue_en;
    logic [4:0]  p_rd, m_rd, issue_rd;
    logic [31:0] p_data, m_data;
    logic        p_ready, m_ready;
    logic        rf_we, issue_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata, busy_mask;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .issue_err(issue_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_valid = 0; p_rd = 0; p_data = 0;
        m_valid = 0; m_rd = 0; m_data = 0;
        issue_en = 0; issue_rd = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        total++; if (issue_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", issue_err); end
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL reset_m_ready got=%b exp=0", m_ready); end
    endtask

    task automatic test_single_p();
        apply_reset();
        p_valid = 1; p_rd = 5; p_data = 32'hDEADBEEF;
        #1;
        total++; if (p_ready !== 1'b1) begin bad++; $display("FAIL sp_p_ready got=%b exp=1", p_ready); end
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL sp_m_ready got=%b exp=0", m_ready); end
        tick();
        p_valid = 0; p_rd = 0; p_data = 0;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL sp_we got=%b exp=1", rf_we); end
        total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL sp_rd got=%0d exp=5", rf_rd); end
        total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sp_wdata got=%h exp=deadbeef", rf_wdata); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sp_we_after got=%b exp=0", rf_we); end
        total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL sp_rd_hold got=%0d exp=5", rf_rd); end
        total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sp_wdata_hold got=%h exp=deadbeef", rf_wdata); end
    endtask

    task automatic test_starvation();
        apply_reset();
        p_valid = 1; p_rd = 3; p_data = 32'hAAAA0003;
        m_valid = 1; m_rd = 7; m_data = 32'hBBBB0007;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (p_ready !== 1'b1 || m_ready !== 1'b0) begin
                bad++; $display("FAIL st_p_wins[%0d] got p=%b m=%b exp p=1 m=0", i, p_ready, m_ready);
            end
            tick();
            total++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'hAAAA0003) begin
                bad++; $display("FAIL st_p_write[%0d] got we=%b rd=%0d d=%h exp we=1 rd=3 d=aaaa0003", i, rf_we, rf_rd, rf_wdata);
            end
        end
        #1;
        total++; if (p_ready !== 1'b0 || m_ready !== 1'b1) begin
            bad++; $display("FAIL st_force got p=%b m=%b exp p=0 m=1", p_ready, m_ready);
        end
        tick();
        m_valid = 0;
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'hBBBB0007) begin
            bad++; $display("FAIL st_m_write got we=%b rd=%0d d=%h exp we=1 rd=7 d=bbbb0007", rf_we, rf_rd, rf_wdata);
        end
        // Counter cleared: with M back, P wins again.
        m_valid = 1; m_rd = 8; m_data = 32'h8;
        #1;
        total++; if (p_ready !== 1'b1 || m_ready !== 1'b0) begin
            bad++; $display("FAIL st_after_clear got p=%b m=%b exp p=1 m=0", p_ready, m_ready);
        end
        p_valid = 0;
        #1;
        total++; if (m_ready !== 1'b1 || p_ready !== 1'b0) begin
            bad++; $display("FAIL st_m_alone got p=%b m=%b exp p=0 m=1", p_ready, m_ready);
        end
        tick();
        m_valid = 0;
        total++; if (rf_rd !== 5'd8 || rf_we !== 1'b1) begin
            bad++; $display("FAIL st_m_alone_write got we=%b rd=%0d exp we=1 rd=8", rf_we, rf_rd);
        end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        issue_en = 1; issue_rd = 9;
        tick();
        issue_en = 0;
        total++; if (busy_mask !== 32'h0000_0200) begin bad++; $display("FAIL sb_set got=%h exp=00000200", busy_mask); end
        // P write to a busy register leaves the scoreboard alone.
        p_valid = 1; p_rd = 9; p_data = 32'h99;
        tick();
        p_valid = 0;
        total++; if (busy_mask !== 32'h0000_0200) begin bad++; $display("FAIL sb_p_busy got=%h exp=00000200", busy_mask); end
        m_valid = 1; m_rd = 9; m_data = 32'h1234;
        tick();
        m_valid = 0;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL sb_clear got=%h exp=0", busy_mask); end
        issue_en = 1; issue_rd = 9;
        tick();
        issue_en = 1; issue_rd = 9;
        m_valid = 1; m_rd = 9; m_data = 32'h5678;
        tick();
        issue_en = 0; m_valid = 0;
        total++; if (busy_mask !== 32'h0000_0200) begin bad++; $display("FAIL sb_set_wins got=%h exp=00000200", busy_mask); end
    endtask

    task automatic test_x0();
        apply_reset();
        issue_en = 1; issue_rd = 6;
        tick();
        issue_en = 0;
        p_valid = 1; p_rd = 0; p_data = 32'hFFFF_FFFF;
        #1;
        total++; if (p_ready !== 1'b1) begin bad++; $display("FAIL x0_p_ready got=%b exp=1", p_ready); end
        tick();
        p_valid = 0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", rf_we); end
        issue_en = 1; issue_rd = 0;
        tick();
        issue_en = 0;
        total++; if (busy_mask !== 32'h0000_0040) begin bad++; $display("FAIL x0_issue got=%h exp=00000040", busy_mask); end
        total++; if (issue_err !== 1'b0) begin bad++; $display("FAIL x0_err got=%b exp=0", issue_err); end
    endtask

    task automatic test_double_issue();
        apply_reset();
        issue_en = 1; issue_rd = 4;
        tick();
        total++; if (issue_err !== 1'b0) begin bad++; $display("FAIL di_first got=%b exp=0", issue_err); end
        tick();
        issue_en = 0;
        total++; if (issue_err !== 1'b1) begin bad++; $display("FAIL di_second got=%b exp=1", issue_err); end
        total++; if (busy_mask !== 32'h0000_0010) begin bad++; $display("FAIL di_busy got=%h exp=00000010", busy_mask); end
        m_valid = 1; m_rd = 4; m_data = 32'h44;
        tick();
        m_valid = 0;
        tick();
        tick();
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL di_clear got=%h exp=0", busy_mask); end
        total++; if (issue_err !== 1'b1) begin bad++; $display("FAIL di_sticky got=%b exp=1", issue_err); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        for (int i = 1; i < 16; i++) begin
            issue_en = 1; issue_rd = 5'(i);
            tick();
        end
        issue_en = 0;
        p_valid = 1; p_rd = 2; p_data = 32'h0000_1234;
        tick();
        p_valid = 0;
        total++; if (rf_we !== 1'b1 || busy_mask !== 32'h0000_FFFE) begin
            bad++; $display("FAIL rm_pre got we=%b busy=%h exp we=1 busy=0000fffe", rf_we, busy_mask);
        end
        #2 rst = 1;
        #1;
        total++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0 || busy_mask !== 32'd0 || issue_err !== 1'b0) begin
            bad++; $display("FAIL rm_async got we=%b rd=%0d d=%h busy=%h err=%b exp all 0", rf_we, rf_rd, rf_wdata, busy_mask, issue_err);
        end
        rst = 0;
        tick();
        p_valid = 1; p_rd = 2; p_data = 32'h0000_CAFE;
        #1;
        total++; if (p_ready !== 1'b1 || rf_we !== 1'b0) begin
            bad++; $display("FAIL rm_accept got p_ready=%b we=%b exp p_ready=1 we=0", p_ready, rf_we);
        end
        tick();
        p_valid = 0;
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h0000_CAFE) begin
            bad++; $display("FAIL rm_write got we=%b rd=%0d d=%h exp we=1 rd=2 d=0000cafe", rf_we, rf_rd, rf_wdata);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_p();
        test_starvation();
        test_scoreboard();
        test_x0();
        test_double_issue();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
